// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM data-port arbiter: FSM states, master ids and the
// request field bundle latched toward the RAM.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_END = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_fields_t;

  function automatic req_fields_t pack_fields(input logic        we,
                                              input logic [3:0]  be,
                                              input logic [31:0] addr,
                                              input logic [31:0] wdata);
    req_fields_t f;
    f.we    = we;
    f.be    = be;
    f.addr  = addr;
    f.wdata = wdata;
    return f;
  endfunction

endpackage

// File: rtl/ram_data_arbiter_rr_arbiter2.sv
// Two-way arbiter with a round-robin pointer; fixed_prio_i makes m0 win ties.
// The pointer remembers which master to favour on the next simultaneous request.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       fixed_prio_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_id_o = M0;
    if (req_i == 2'b11) begin
      gnt_id_o = fixed_prio_i ? M0 : ptr_q;
    end else if (req_i[1]) begin
      gnt_id_o = M1;
    end
    gnt_o = 2'b00;
    if (|req_i) begin
      gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (update_i && |req_i) begin
      ptr_d = ~gnt_id_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= M0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_data_arbiter.sv
// Shares the RAM data port between two masters: arbitrates in IDLE, runs the
// require/begin/end handshake, and routes read data, done and error back.
//
// state    | meaning
// IDLE     | no transfer; arbitrate and latch the winner's fields
// ISSUE    | s_require high, waiting for s_begin (or an early s_end)
// WAIT_END | request accepted, waiting for s_end
// DONE     | one-cycle done (and error on timeout) to the owning master
module ram_data_arbiter
  import ram_arb_pkg::*;
#(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_require,
  input  logic        m0_write_enable,
  input  logic [3:0]  m0_byte_enable_map,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write,
  output logic [31:0] m0_read,
  output logic        m0_done,
  output logic        m0_error,
  input  logic        m1_require,
  input  logic        m1_write_enable,
  input  logic [3:0]  m1_byte_enable_map,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write,
  output logic [31:0] m1_read,
  output logic        m1_done,
  output logic        m1_error,
  output logic        s_require,
  output logic        s_write_enable,
  output logic [3:0]  s_byte_enable_map,
  output logic [31:0] s_address,
  output logic [31:0] s_write,
  input  logic [31:0] s_read,
  input  logic        s_begin,
  input  logic        s_end,
  output logic        busy,
  output logic        grant_id
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_q;
  req_fields_t fields_q;
  logic        s_require_q;
  logic        grant_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] m0_read_q, m1_read_q;
  logic        m0_done_q, m1_done_q, m0_error_q, m1_error_q;

  logic [1:0]  gnt;
  logic        gnt_id;
  req_fields_t m0_fields, m1_fields;

  assign m0_fields = pack_fields(m0_write_enable, m0_byte_enable_map, m0_address, m0_write);
  assign m1_fields = pack_fields(m1_write_enable, m1_byte_enable_map, m1_address, m1_write);

  rr_arbiter2 u_arb (
    .clk          (clk),
    .reset        (reset),
    .req_i        ({m1_require, m0_require}),
    .update_i     (state_q == IDLE),
    .fixed_prio_i (PRIORITY_MODE != 0),
    .gnt_o        (gnt),
    .gnt_id_o     (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      fields_q    <= '0;
      s_require_q <= 1'b0;
      grant_q     <= M0;
      cnt_q       <= '0;
      m0_read_q   <= '0;
      m1_read_q   <= '0;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      m0_error_q  <= 1'b0;
      m1_error_q  <= 1'b0;
    end else begin
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_error_q <= 1'b0;
      m1_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            fields_q    <= gnt[1] ? m1_fields : m0_fields;
            grant_q     <= gnt_id;
            s_require_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE, WAIT_END: begin
          // An s_end without a prior s_begin counts as accept-and-finish.
          if (s_end || cnt_q == TMO_LAST) begin
            s_require_q <= 1'b0;
            state_q     <= DONE;
            if (grant_q == M1) begin
              m1_done_q  <= 1'b1;
              m1_error_q <= ~s_end;
              m1_read_q  <= s_end ? s_read : 32'h0;
            end else begin
              m0_done_q  <= 1'b1;
              m0_error_q <= ~s_end;
              m0_read_q  <= s_end ? s_read : 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (state_q == ISSUE && s_begin) begin
              s_require_q <= 1'b0;
              state_q     <= WAIT_END;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_require         = s_require_q;
  assign s_write_enable    = fields_q.we;
  assign s_byte_enable_map = fields_q.be;
  assign s_address         = fields_q.addr;
  assign s_write           = fields_q.wdata;
  assign m0_read           = m0_read_q;
  assign m1_read           = m1_read_q;
  assign m0_done           = m0_done_q;
  assign m1_done           = m1_done_q;
  assign m0_error          = m0_error_q;
  assign m1_error          = m1_error_q;
  assign busy              = (state_q != IDLE);
  assign grant_id          = grant_q;

endmodule

// File: tb/tb_ram_data_arbiter.sv
// Bench for ram_data_arbiter: a round-robin and a fixed-priority instance, each
// with a small word RAM model, driven by shared master stimulus.
module tb_ram_data_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m0_require, m0_write_enable, m1_require, m1_write_enable;
  logic [3:0]  m0_byte_enable_map, m1_byte_enable_map;
  logic [31:0] m0_address, m0_write, m1_address, m1_write;
  logic        hang, skip_begin;
  int          lat_cfg;

  int checks = 0;
  int failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] m0_read, m1_read, s_address, s_write, s_read;
    logic        m0_done, m0_error, m1_done, m1_error;
    logic        s_require, s_write_enable, s_begin, s_end, busy, grant_id;
    logic [3:0]  s_byte_enable_map;
    logic [31:0] mem [0:255];
    logic        rstage;
    int          rcnt;
    int          ndone = 0;
    int          nboth = 0;
    logic        rec_mst [64];
    logic        rec_gid [64];
    logic        rec_err [64];
    logic [31:0] rec_rd  [64];

    ram_data_arbiter #(.PRIORITY_MODE(k), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .m0_require(m0_require), .m0_write_enable(m0_write_enable),
      .m0_byte_enable_map(m0_byte_enable_map), .m0_address(m0_address),
      .m0_write(m0_write), .m0_read(m0_read), .m0_done(m0_done), .m0_error(m0_error),
      .m1_require(m1_require), .m1_write_enable(m1_write_enable),
      .m1_byte_enable_map(m1_byte_enable_map), .m1_address(m1_address),
      .m1_write(m1_write), .m1_read(m1_read), .m1_done(m1_done), .m1_error(m1_error),
      .s_require(s_require), .s_write_enable(s_write_enable),
      .s_byte_enable_map(s_byte_enable_map), .s_address(s_address), .s_write(s_write),
      .s_read(s_read), .s_begin(s_begin), .s_end(s_end),
      .busy(busy), .grant_id(grant_id)
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[4] = 32'hDEADBEEF;
      mem[8] = 32'h11223344;
    end

    // RAM model: begin one cycle after require, end lat_cfg+1 cycles later.
    always @(posedge clk) begin
      s_begin <= 1'b0;
      s_end   <= 1'b0;
      if (!reset) begin
        rstage <= 1'b0;
        rcnt   <= 0;
      end else if (!rstage) begin
        if (s_require && !s_begin && !s_end && !hang) begin
          if (skip_begin) begin
            s_end  <= 1'b1;
            s_read <= mem[s_address[9:2]];
            if (s_write_enable)
              for (int b = 0; b < 4; b++)
                if (s_byte_enable_map[b]) mem[s_address[9:2]][8*b +: 8] <= s_write[8*b +: 8];
          end else begin
            s_begin <= 1'b1;
            rstage  <= 1'b1;
            rcnt    <= lat_cfg;
          end
        end
      end else if (rcnt == 0) begin
        s_end  <= 1'b1;
        rstage <= 1'b0;
        s_read <= mem[s_address[9:2]];
        if (s_write_enable)
          for (int b = 0; b < 4; b++)
            if (s_byte_enable_map[b]) mem[s_address[9:2]][8*b +: 8] <= s_write[8*b +: 8];
      end else begin
        rcnt <= rcnt - 1;
      end
    end

    always @(negedge clk) begin
      if (reset) begin
        if (m0_done && m1_done) nboth++;
        if (m0_done || m1_done) begin
          rec_mst[ndone % 64] = m1_done;
          rec_gid[ndone % 64] = grant_id;
          rec_err[ndone % 64] = m1_done ? m1_error : m0_error;
          rec_rd[ndone % 64]  = m1_done ? m1_read : m0_read;
          ndone++;
        end
      end
    end
  end

  typedef struct {
    logic        mst;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        skip;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic set_m(input logic mst, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (mst) begin
      m1_require = req; m1_write_enable = we; m1_byte_enable_map = be;
      m1_address = addr; m1_write = wd;
    end else begin
      m0_require = req; m0_write_enable = we; m0_byte_enable_map = be;
      m0_address = addr; m0_write = wd;
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   base;
    int   n;
    int   idx;
    v    = vecs[i];
    base = g_dut[0].ndone;
    idx  = base % 64;
    skip_begin = v.skip;
    set_m(v.mst, 1'b1, v.we, v.be, v.addr, v.wdata);
    if (i == 0) begin
      @(negedge clk);
      chk1("lat_sreq_before", g_dut[0].s_require, 1'b0);
      @(negedge clk);
      chk1("lat_sreq_next", g_dut[0].s_require, 1'b1);
    end
    n = 0;
    while (g_dut[0].ndone == base && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    set_m(v.mst, 1'b0, v.we, v.be, v.addr, v.wdata);
    skip_begin = 1'b0;
    chk1($sformatf("vec%0d_in_time", i), n < 100, 1'b1);
    chk32($sformatf("vec%0d_ndone", i), 32'(g_dut[0].ndone - base), 32'd1);
    chk1($sformatf("vec%0d_mst", i), g_dut[0].rec_mst[idx], v.mst);
    chk1($sformatf("vec%0d_gid", i), g_dut[0].rec_gid[idx], v.mst);
    chk1($sformatf("vec%0d_err", i), g_dut[0].rec_err[idx], 1'b0);
    if (v.chk_rd) chk32($sformatf("vec%0d_rd", i), g_dut[0].rec_rd[idx], v.exp_rd);
    chk1($sformatf("vec%0d_done_1cyc", i), g_dut[0].m0_done | g_dut[0].m1_done, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base0, base1, n, idx;
    logic [6:0] exp_rr, exp_fx;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h10, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h20, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 4'h0, 32'h20, 32'h0,        1'b0, 1'b1, 32'h1122A5A5};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 32'h10, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 4'hF, 32'h24, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 32'h24, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b1, 4'h8, 32'h24, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 4'h0, 32'h24, 32'h0,        1'b1, 1'b1, 32'hFFFEF00D};

    reset = 1'b0; hang = 1'b0; skip_begin = 1'b0; lat_cfg = 1;
    set_m(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", g_dut[0].busy, 1'b0);
    chk1("rst_sreq", g_dut[0].s_require, 1'b0);
    chk1("rst_gid", g_dut[0].grant_id, 1'b0);
    chk1("rst_m0_done", g_dut[0].m0_done, 1'b0);
    chk32("rst_saddr", g_dut[0].s_address, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset clears read registers and the round-robin pointer.
    reset = 1'b0;
    @(posedge clk); #1;
    chk32("rst2_m0_read", g_dut[0].m0_read, 32'h0);
    chk1("rst2_gid", g_dut[0].grant_id, 1'b0);
    reset = 1'b1;

    // Both masters requesting continuously.
    base0 = g_dut[0].ndone;
    base1 = g_dut[1].ndone;
    set_m(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    set_m(1'b1, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
    n = 0;
    while ((g_dut[0].ndone < base0 + 6 || g_dut[1].ndone < base1 + 6) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    m0_require = 1'b0;
    while ((g_dut[0].ndone < base0 + 7 || g_dut[1].ndone < base1 + 7) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    m1_require = 1'b0;
    chk1("arb_in_time", n < 400, 1'b1);
    exp_rr = 7'b1101010;
    exp_fx = 7'b1000000;
    for (int j = 0; j < 7; j++) begin
      idx = (base0 + j) % 64;
      chk1($sformatf("rr_grant%0d", j), g_dut[0].rec_mst[idx], exp_rr[j]);
      chk1($sformatf("rr_gid%0d", j), g_dut[0].rec_gid[idx], exp_rr[j]);
      if (!exp_rr[j]) chk32($sformatf("rr_rd%0d", j), g_dut[0].rec_rd[idx], 32'hDEADBEEF);
      idx = (base1 + j) % 64;
      chk1($sformatf("fx_grant%0d", j), g_dut[1].rec_mst[idx], exp_fx[j]);
      chk1($sformatf("fx_gid%0d", j), g_dut[1].rec_gid[idx], exp_fx[j]);
    end

    // RAM that never ends: timeout after 16 cycles in ISSUE.
    @(posedge clk); #1;
    hang = 1'b1;
    set_m(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    @(posedge clk); #1;
    chk1("tmo_sreq_issue", g_dut[0].s_require, 1'b1);
    n = 0;
    while (!g_dut[0].m0_done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk32("tmo_cycles", 32'(n), 32'd16);
    chk1("tmo_error", g_dut[0].m0_error, 1'b1);
    chk32("tmo_read", g_dut[0].m0_read, 32'h0);
    chk1("tmo_sreq_low", g_dut[0].s_require, 1'b0);
    chk1("tmo_m1_quiet", g_dut[0].m1_done | g_dut[0].m1_error, 1'b0);
    chk1("tmo_fx_error", g_dut[1].m0_error, 1'b1);
    m0_require = 1'b0;
    hang = 1'b0;
    @(posedge clk); #1;
    chk1("tmo_done_1cyc", g_dut[0].m0_done | g_dut[0].m0_error, 1'b0);

    // Reset while waiting for s_end drops the transfer.
    lat_cfg = 6;
    set_m(1'b1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(g_dut[0].busy && !g_dut[0].s_require) && n < 40);
    chk1("mr_reached_wait", n < 40, 1'b1);
    base0 = g_dut[0].ndone;
    reset = 1'b0;
    @(posedge clk); #1;
    chk1("mr_busy", g_dut[0].busy, 1'b0);
    chk1("mr_gid", g_dut[0].grant_id, 1'b0);
    chk1("mr_done", g_dut[0].m1_done, 1'b0);
    chk32("mr_read", g_dut[0].m1_read, 32'h0);
    reset = 1'b1;
    lat_cfg = 1;
    n = 0;
    while (g_dut[0].ndone == base0 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    m1_require = 1'b0;
    chk1("mr_in_time", n < 60, 1'b1);
    idx = base0 % 64;
    chk1("mr_fresh_mst", g_dut[0].rec_mst[idx], 1'b1);
    chk1("mr_fresh_err", g_dut[0].rec_err[idx], 1'b0);
    chk32("mr_fresh_rd", g_dut[0].rec_rd[idx], 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    chk32("mr_single_done", 32'(g_dut[0].ndone - base0), 32'd1);

    chk32("no_dual_done_rr", 32'(g_dut[0].nboth), 32'd0);
    chk32("no_dual_done_fx", 32'(g_dut[1].nboth), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
